// File: rtl/lfsr_ranged.sv
// Parametrised Fibonacci LFSR with runtime reseed, plus a request/response port
// returning values in [0, bound) by bounded rejection sampling.
//   state | meaning
//   IDLE  | ready for a request
//   DRAW  | testing candidates, LFSR steps every cycle
//   DONE  | result held until the consumer accepts it
module lfsr_ranged #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hD008,
  parameter logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             next_i,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] rand_o,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] bound_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_data_o
);

  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  if (SEED == '0) begin : g_seed_chk
    $error("lfsr_ranged: SEED must be nonzero");
  end
  if (WIDTH < 4) begin : g_width_chk
    $error("lfsr_ranged: WIDTH must be at least 4");
  end
  if (MAX_TRIES < 1) begin : g_tries_chk
    $error("lfsr_ranged: MAX_TRIES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, DRAW, DONE} fsm_t;

  fsm_t             fsm, fsm_next;
  logic [WIDTH-1:0] state, step;
  logic [WIDTH-1:0] bnd, bnd_next;
  logic [WIDTH-1:0] mask, mask_next;
  logic [WIDTH-1:0] data, data_next;
  logic [WIDTH-1:0] bnd_m1, req_mask, cand;
  logic [TW-1:0]    tries, tries_next;

  assign step = {state[WIDTH-2:0], ^(state & TAPS)};

  // A zero state can never leave zero on its own, so it is forced back to SEED.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= SEED;
    end else if (state == '0) begin
      state <= SEED;
    end else if (seed_valid_i) begin
      state <= (seed_i == '0) ? SEED : seed_i;
    end else if (next_i || fsm == DRAW) begin
      state <= step;
    end
  end

  // Smear bound-1 rightwards to get the smallest 2^k-1 covering it.
  always_comb begin
    bnd_m1   = bound_i - WIDTH'(1);
    req_mask = bnd_m1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      req_mask = req_mask | (bnd_m1 >> i);
    end
    if (bound_i == '0) begin
      req_mask = '1;
    end
  end

  assign cand = state & mask;

  always_comb begin
    fsm_next     = fsm;
    bnd_next     = bnd;
    mask_next    = mask;
    tries_next   = tries;
    data_next    = data;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (fsm)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          bnd_next   = bound_i;
          mask_next  = req_mask;
          tries_next = '0;
          fsm_next   = DRAW;
        end
      end
      DRAW: begin
        if (bnd == '0 || cand < bnd) begin
          data_next = cand;
          fsm_next  = DONE;
        end else if (tries == TW'(MAX_TRIES - 1)) begin
          // cand <= mask < 2*bnd, so one subtraction lands inside the range
          data_next = cand - bnd;
          fsm_next  = DONE;
        end else begin
          tries_next = tries + TW'(1);
        end
      end
      DONE: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm   <= IDLE;
      bnd   <= '0;
      mask  <= '0;
      tries <= '0;
      data  <= '0;
    end else begin
      fsm   <= fsm_next;
      bnd   <= bnd_next;
      mask  <= mask_next;
      tries <= tries_next;
      data  <= data_next;
    end
  end

  assign rand_o      = state;
  assign resp_data_o = data;

endmodule

// File: tb/tb_lfsr_ranged.sv
// Self-checking bench for lfsr_ranged: LFSR sequence, reseed, period and the
// ranged request port, with expected results queued at request time.
module tb_lfsr_ranged;

  localparam int MT = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        next_i;
  logic        seed_valid_i;
  logic [15:0] seed_i;
  logic [15:0] rand_o;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [15:0] bound_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [15:0] resp_data_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model;
  logic [15:0] exp_q[$];
  int          lat_q[$];

  lfsr_ranged dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .next_i       (next_i),
    .seed_valid_i (seed_valid_i),
    .seed_i       (seed_i),
    .rand_o       (rand_o),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .bound_i      (bound_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hD008)};
  endfunction

  // Predict one ranged draw from the model state and queue its result/latency.
  task automatic predict(input logic [15:0] b);
    int          m;
    logic [15:0] m16, cand;
    m = 0;
    if (b == 16'h0) m = 32'hFFFF;
    else while (m < int'(b) - 1) m = m * 2 + 1;
    m16 = m[15:0];
    for (int t = 0; t < MT; t++) begin
      cand  = model & m16;
      model = lfsr_step(model);
      if (b == 16'h0 || cand < b) begin
        exp_q.push_back(cand);
        lat_q.push_back(t + 2);
        return;
      end
      if (t == MT - 1) begin
        exp_q.push_back(cand - b);
        lat_q.push_back(MT + 1);
      end
    end
  endtask

  task automatic do_req(input logic [15:0] b, input int stall_max);
    logic [15:0] held, exp_d;
    int          lat, exp_l, stall;
    check("req_ready_idle", req_ready_o, 1);
    predict(b);
    req_valid_i = 1'b1;
    bound_i     = b;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    bound_i     = 16'($urandom);
    lat = 1;
    while (!resp_valid_o && lat <= MT + 2) begin
      check("busy_ready", req_ready_o, 0);
      @(negedge clk_i);
      lat++;
    end
    exp_d = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    check("resp_seen", resp_valid_o, 1);
    if (!resp_valid_o) return;
    check("latency", lat, exp_l);
    held  = resp_data_o;
    stall = int'($urandom_range(stall_max));
    repeat (stall) begin
      check("stall_valid", resp_valid_o, 1);
      check("stall_stable", resp_data_o, held);
      check("stall_ready", req_ready_o, 0);
      @(negedge clk_i);
    end
    check("resp_data", resp_data_o, exp_d);
    if (b != 16'h0) check("in_range", resp_data_o < b, 1);
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    check("idle_ready", req_ready_o, 1);
    check("idle_valid", resp_valid_o, 0);
    check("state_after", rand_o, model);
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_valid_i = 1'b1;
    seed_i       = s;
    @(negedge clk_i);
    seed_valid_i = 1'b0;
    model        = (s == 16'h0) ? 16'h0001 : s;
  endtask

  initial begin
    logic [15:0] step_tab [4];
    logic [15:0] s0;
    int          first_ret, track_err;
    logic        zero_seen;

    rst_i = 1'b1; next_i = 1'b0; seed_valid_i = 1'b0; seed_i = 16'h0;
    req_valid_i = 1'b0; bound_i = 16'h0; resp_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_rand", rand_o, 16'h0001);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_resp_data", resp_data_o, 16'h0000);
    rst_i = 1'b0;
    model = 16'h0001;

    step_tab = '{16'h0002, 16'h0004, 16'h0008, 16'h0011};
    next_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("step_seq", rand_o, step_tab[i]);
    end
    next_i = 1'b0;
    @(negedge clk_i);
    check("hold", rand_o, 16'h0011);

    load_seed(16'h0000);
    check("seed_zero", rand_o, 16'h0001);
    next_i = 1'b1;
    load_seed(16'hACE1);
    next_i = 1'b0;
    check("seed_over_next", rand_o, 16'hACE1);

    do_req(16'd1, 0);
    do_req(16'd0, 1);
    do_req(16'd5, 2);
    do_req(16'd7, 1);
    do_req(16'd8, 1);
    do_req(16'd9, 2);
    do_req(16'd100, 1);
    do_req(16'h8001, 1);

    // Seed 0xFF12 keeps the top bit set for eight draws: forces the fallback.
    load_seed(16'hFF12);
    do_req(16'h8001, 2);

    // Reseed during the single DRAW cycle of a bound=0 request.
    s0 = model;
    req_valid_i = 1'b1;
    bound_i     = 16'h0;
    @(negedge clk_i);
    req_valid_i  = 1'b0;
    seed_valid_i = 1'b1;
    seed_i       = 16'h1234;
    @(negedge clk_i);
    seed_valid_i = 1'b0;
    check("draw_seed_valid", resp_valid_o, 1);
    check("draw_seed_data", resp_data_o, s0);
    check("draw_seed_state", rand_o, 16'h1234);
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    model = 16'h1234;

    for (int i = 0; i < 1000; i++) do_req(16'd5, 3);

    // Asynchronous reset in the middle of a long DRAW.
    load_seed(16'hFF12);
    req_valid_i = 1'b1;
    bound_i     = 16'h8001;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("arst_resp_valid", resp_valid_o, 0);
    check("arst_req_ready", req_ready_o, 1);
    check("arst_rand", rand_o, 16'h0001);
    @(negedge clk_i);
    rst_i = 1'b0;
    model = 16'h0001;
    do_req(16'd5, 1);

    load_seed(16'h0001);
    first_ret = 0;
    track_err = 0;
    zero_seen = 1'b0;
    next_i    = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      @(negedge clk_i);
      model = lfsr_step(model);
      if (rand_o == 16'h0) zero_seen = 1'b1;
      if (rand_o != model) track_err++;
      if (rand_o == 16'h0001 && first_ret == 0) first_ret = i;
    end
    next_i = 1'b0;
    check("period", first_ret, 65535);
    check("never_zero", zero_seen, 0);
    check("period_track", track_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
